uart_rx_edge_bit_sampler: RTL and testbench

Upstream companion of the UART RX control FSM. It synchronises the raw serial line and provides the FSM with three things: the synchronised line level S_DATA, the oversampling edge_count / bit_count pair, and a majority-voted sampled_bit. Downstream, the parity, start and stop checkers and the deserializer consume sampled_bit. It is a single clock domain (the RX oversampling clock).

---
 rtl/uart_rx_edge_bit_sampler_pkg.sv | 17 +
 rtl/uart_rx_edge_bit_sampler_if.sv | 26 ++
 rtl/uart_rx_edge_bit_sampler_bit_sync.sv | 24 ++
 rtl/uart_rx_edge_bit_sampler.sv | 88 ++++++++
 tb/tb_uart_rx_edge_bit_sampler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_edge_bit_sampler_pkg.sv
// Shared constants and helpers for the UART RX edge/bit sampler slice.
// Legal oversampling ratios and the idle line level live here so the FSM side can reuse them.
package uart_rx_pkg;

  localparam int   DEFAULT_PRESCALE_WIDTH = 6;
  localparam int   DEFAULT_BIT_CNT_WIDTH  = 4;
  localparam logic UART_IDLE_LEVEL        = 1'b1;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_sampler_if.sv
// Bundle between the RX control FSM (master) and the edge/bit sampler (slave).
interface uart_rx_edge_bit_sampler_if import uart_rx_pkg::*; #(
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH,
  parameter int BIT_CNT_WIDTH  = DEFAULT_BIT_CNT_WIDTH
);

  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      edge_bit_en;
  logic                      dat_samp_en;
  logic                      S_DATA;
  logic [PRESCALE_WIDTH-1:0] edge_count;
  logic [BIT_CNT_WIDTH-1:0]  bit_count;
  logic                      sampled_bit;
  logic                      sample_valid;

  modport master (
    output Prescale, edge_bit_en, dat_samp_en,
    input  S_DATA, edge_count, bit_count, sampled_bit, sample_valid
  );

  modport slave (
    input  Prescale, edge_bit_en, dat_samp_en,
    output S_DATA, edge_count, bit_count, sampled_bit, sample_valid
  );

endinterface

// File: rtl/uart_rx_edge_bit_sampler_bit_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; resets to the idle level.
// SYNC_STAGES must be at least 2.
module uart_rx_bit_sync import uart_rx_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic RX_IN,
  output logic S_DATA
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{UART_IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
    end
  end

  assign S_DATA = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_edge_bit_sampler.sv
// Oversampling edge/bit counters and mid-bit majority voter feeding the UART RX FSM.
// The serial line is synchronised first; every output is a flop output.
module uart_rx_edge_bit_sampler import uart_rx_pkg::*; #(
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH,
  parameter int BIT_CNT_WIDTH  = DEFAULT_BIT_CNT_WIDTH,
  parameter int SYNC_STAGES    = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic RX_IN,
  uart_rx_edge_bit_sampler_if.slave bus
);

  logic                      s_data;
  logic [PRESCALE_WIDTH-1:0] edge_count_q;
  logic [BIT_CNT_WIDTH-1:0]  bit_count_q;
  logic [PRESCALE_WIDTH-1:0] presc_m1;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] half_m1;
  logic [PRESCALE_WIDTH-1:0] half_p1;
  logic                      s0_q;
  logic                      s1_q;
  logic                      sampled_bit_q;
  logic                      sample_valid_q;

  uart_rx_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bit_sync (
    .CLK   (CLK),
    .RST   (RST),
    .RX_IN (RX_IN),
    .S_DATA(s_data)
  );

  always_comb begin
    presc_m1 = bus.Prescale - PRESCALE_WIDTH'(1);
    half     = bus.Prescale >> 1;
    half_m1  = half - PRESCALE_WIDTH'(1);
    half_p1  = half + PRESCALE_WIDTH'(1);
  end

  // The >= wrap keeps the counter bounded even if Prescale shrinks mid-bit or is illegal.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_count_q <= '0;
      bit_count_q  <= '0;
    end else if (!bus.edge_bit_en) begin
      edge_count_q <= '0;
      bit_count_q  <= '0;
    end else if (edge_count_q >= presc_m1) begin
      edge_count_q <= '0;
      if (!(&bit_count_q)) begin
        bit_count_q <= bit_count_q + BIT_CNT_WIDTH'(1);
      end
    end else begin
      edge_count_q <= edge_count_q + PRESCALE_WIDTH'(1);
    end
  end

  // Third sample is taken straight from the line so the vote lands at H+2.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0_q           <= UART_IDLE_LEVEL;
      s1_q           <= UART_IDLE_LEVEL;
      sampled_bit_q  <= UART_IDLE_LEVEL;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (bus.dat_samp_en) begin
        if (edge_count_q == half_m1) begin
          s0_q <= s_data;
        end
        if (edge_count_q == half) begin
          s1_q <= s_data;
        end
        if (edge_count_q == half_p1) begin
          sampled_bit_q  <= maj3(s0_q, s1_q, s_data);
          sample_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.S_DATA       = s_data;
  assign bus.edge_count   = edge_count_q;
  assign bus.bit_count    = bit_count_q;
  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Randomised self-checking bench for uart_rx_edge_bit_sampler against a closed-form reference model.
module tb_uart_rx_edge_bit_sampler;
  import uart_rx_pkg::*;

  localparam int PW = 6;
  localparam int BW = 4;
  localparam int SS = 2;

  logic CLK = 1'b0;
  logic RST;
  logic RX_IN;

  uart_rx_edge_bit_sampler_if #(.PRESCALE_WIDTH(PW), .BIT_CNT_WIDTH(BW)) bus ();

  uart_rx_edge_bit_sampler #(
    .PRESCALE_WIDTH(PW),
    .BIT_CNT_WIDTH (BW),
    .SYNC_STAGES   (SS)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .RX_IN(RX_IN),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: n = consecutive enabled clocks, so edge = n % p and bit = min(n / p, 15).
  int n = 0;
  int p = PRESC_8;
  bit rx_q[$];
  bit mid[64];
  bit exp_sb = 1'b1;
  bit exp_sv = 1'b0;

  bit frame_mode = 1'b0;
  bit frame_bits[11];
  int frame_pulses = 0;
  int frame_max_bit = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int expBit();
    int b;
    b = n / p;
    if (b > 15) b = 15;
    return b;
  endfunction

  task automatic modelReset();
    n = 0;
    rx_q.delete();
    for (int i = 0; i < SS; i++) rx_q.push_back(1'b1);
    for (int i = 0; i < 64; i++) mid[i] = 1'b1;
    exp_sb = 1'b1;
    exp_sv = 1'b0;
  endtask

  // One clock: check what is visible now, then drive the next inputs and advance the model.
  task automatic applyStimulus(input bit rx, input bit ebe, input bit dse);
    int  cur_edge;
    int  h;
    bit  cur_sd;
    @(negedge CLK);
    checkOutput("edge_count", bus.edge_count, n % p);
    checkOutput("bit_count", bus.bit_count, expBit());
    checkOutput("S_DATA", bus.S_DATA, rx_q[0]);
    checkOutput("sampled_bit", bus.sampled_bit, exp_sb);
    checkOutput("sample_valid", bus.sample_valid, exp_sv);
    if (frame_mode) begin
      if (int'(bus.bit_count) > frame_max_bit) frame_max_bit = int'(bus.bit_count);
      if (exp_sv) begin
        frame_pulses++;
        checkOutput("frame_bit", bus.sampled_bit, frame_bits[n / p]);
      end
    end
    cur_edge = n % p;
    h = p / 2;
    cur_sd = rx_q[0];
    exp_sv = 1'b0;
    if (dse) begin
      if (cur_edge == h - 1 || cur_edge == h) mid[cur_edge] = cur_sd;
      if (cur_edge == h + 1) begin
        exp_sv = 1'b1;
        exp_sb = (int'(mid[h - 1]) + int'(mid[h]) + int'(cur_sd)) >= 2;
      end
    end
    RX_IN = rx;
    bus.edge_bit_en = ebe;
    bus.dat_samp_en = dse;
    n = ebe ? n + 1 : 0;
    void'(rx_q.pop_front());
    rx_q.push_back(rx);
  endtask

  task automatic resetDut();
    RX_IN = 1'b1;
    bus.edge_bit_en = 1'b0;
    bus.dat_samp_en = 1'b0;
    RST = 1'b1;
    #1;
    checkOutput("rst_edge_count", bus.edge_count, 0);
    checkOutput("rst_bit_count", bus.bit_count, 0);
    checkOutput("rst_S_DATA", bus.S_DATA, 1);
    checkOutput("rst_sampled_bit", bus.sampled_bit, 1);
    checkOutput("rst_sample_valid", bus.sample_valid, 0);
    modelReset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic setPrescale(input int v);
    bus.Prescale = PW'(v);
    p = v;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic voteBit(input bit a, input bit b, input bit c, input bit expv, input string tag);
    int h;
    bit rx;
    h = p / 2;
    for (int e = 0; e < p; e++) begin
      rx = ~expv;
      if (e == h - 3) rx = a;
      if (e == h - 2) rx = b;
      if (e == h - 1) rx = c;
      applyStimulus(rx, 1'b1, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput(tag, bus.sampled_bit, expv);
  endtask

  task automatic sendFrame(input logic [7:0] data, input bit glitchy);
    bit rx;
    frame_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame_bits[1 + i] = data[i];
    frame_bits[9]  = ^data;
    frame_bits[10] = 1'b1;
    frame_mode = !glitchy;
    frame_pulses = 0;
    frame_max_bit = 0;
    for (int b = 0; b < 11; b++) begin
      for (int e = 0; e < p; e++) begin
        rx = frame_bits[b];
        if (glitchy && $urandom_range(0, 7) == 0) rx = ~rx;
        applyStimulus(rx, 1'b1, 1'b1);
      end
    end
    if (!glitchy) begin
      checkOutput("frame_pulses", frame_pulses, 11);
      checkOutput("frame_max_bit", frame_max_bit, 10);
    end
    frame_mode = 1'b0;
    idle(3);
  endtask

  initial begin
    RX_IN = 1'b1;
    bus.edge_bit_en = 1'b0;
    bus.dat_samp_en = 1'b0;
    setPrescale(PRESC_8);
    resetDut();
    idle(2);

    // Reset mid-count at edge_count 5 with the line low.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    checkOutput("pre_reset_edge", bus.edge_count, 5);
    resetDut();
    idle(3);

    // Three full bit-times, then drop the enable exactly on the wrap cycle.
    for (int i = 0; i < 24 + 7; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("clear_edge", bus.edge_count, 0);
    checkOutput("clear_bit", bus.bit_count, 0);

    setPrescale(PRESC_16);
    idle(1);
    voteBit(1'b1, 1'b0, 1'b0, 1'b0, "vote_100");
    voteBit(1'b0, 1'b1, 1'b1, 1'b1, "vote_011");
    voteBit(1'b0, 1'b1, 1'b0, 1'b0, "vote_010");
    voteBit(1'b1, 1'b0, 1'b1, 1'b1, "vote_101");

    setPrescale(PRESC_8);
    idle(1);
    sendFrame(8'h5A, 1'b0);

    for (int f = 0; f < 8; f++) begin
      setPrescale(PRESC_8 << $urandom_range(0, 2));
      idle(1);
      sendFrame(8'($urandom), bit'(f % 2));
    end

    // Saturation: 20 bit-times at Prescale 8.
    setPrescale(PRESC_8);
    idle(1);
    for (int i = 0; i < 160; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bit_saturate", bus.bit_count, 15);
    idle(2);

    // Single-cycle low glitch must reach S_DATA SYNC_STAGES clocks later.
    applyStimulus(1'b0, 1'b0, 1'b0);
    idle(SS + 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
